qam_coherent_demod: RTL and testbench

Receive-side counterpart to the carrier NCO/modulator path. It mixes each received sample with local cosine and sine references, supplied by two NCO instances running at the TX carrier step. It integrates the I and Q products over one symbol period (integrate-and-dump), then slices the dumped I/Q sums into 16-QAM Gray-coded symbol bits. It sits between the ADC/sample source and the bit deserializer.

---
 rtl/qam_demod_pkg.sv | 32 +++
 rtl/qam_coherent_demod_if.sv | 30 +++
 rtl/qam_axis_slicer.sv | 28 ++
 rtl/qam_coherent_demod.sv | 137 +++++++++++++
 tb/tb_qam_coherent_demod.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/qam_demod_pkg.sv
// Shared definitions for the 16-QAM coherent demodulator.
// Holds the Gray level codes, the FSM state type and a clog2 helper that
// is used to size the counter and to check parameter widths.
package qam_demod_pkg;

  // Gray-coded per-axis decision levels.
  localparam logic [1:0] LVL_NEG_OUT = 2'b00;
  localparam logic [1:0] LVL_NEG_IN  = 2'b01;
  localparam logic [1:0] LVL_POS_IN  = 2'b11;
  localparam logic [1:0] LVL_POS_OUT = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Ceiling log2; values 0 and 1 both return 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    if (v > 1) begin
      x = v - 1;
      while (x > 0) begin
        r = r + 1;
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/qam_coherent_demod_if.sv
// Sample-in / symbol-out bus of the coherent demodulator.
// master: sample source (drives en/sync/rx_sample/cos_ref/sin_ref, receives results)
// slave : demodulator (receives samples, drives i_acc/q_acc/sym_bits/sym_valid)
interface qam_coherent_demod_if #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned REF_WIDTH    = 16,
  parameter int unsigned ACC_WIDTH    = 40
);

  logic                           en;
  logic                           sync;
  logic signed [SAMPLE_WIDTH-1:0] rx_sample;
  logic signed [REF_WIDTH-1:0]    cos_ref;
  logic signed [REF_WIDTH-1:0]    sin_ref;
  logic signed [ACC_WIDTH-1:0]    i_acc;
  logic signed [ACC_WIDTH-1:0]    q_acc;
  logic [3:0]                     sym_bits;
  logic                           sym_valid;

  modport master (
    output en, sync, rx_sample, cos_ref, sin_ref,
    input  i_acc, q_acc, sym_bits, sym_valid
  );

  modport slave (
    input  en, sync, rx_sample, cos_ref, sin_ref,
    output i_acc, q_acc, sym_bits, sym_valid
  );

endinterface

// File: rtl/qam_axis_slicer.sv
// Combinational 4-level Gray slicer for one axis of a 16-QAM constellation.
// Ports: v_i       signed integrated axis value
//        level_c_o 2-bit Gray level (unregistered)
module qam_axis_slicer
  import qam_demod_pkg::*;
#(
  parameter int unsigned                 ACC_WIDTH = 40,
  parameter logic signed [ACC_WIDTH-1:0] THRESH    = ACC_WIDTH'(1) << 28
) (
  input  logic signed [ACC_WIDTH-1:0] v_i,
  output logic [1:0]                  level_c_o
);

  localparam logic signed [ACC_WIDTH-1:0] NEG_THRESH = -THRESH;

  // Negativity is taken from the sign bit so zero lands on the inner positive level.
  always_comb begin
    level_c_o = LVL_POS_IN;
    if (!v_i[ACC_WIDTH-1]) begin
      if (v_i >= THRESH) level_c_o = LVL_POS_OUT;
      else               level_c_o = LVL_POS_IN;
    end else begin
      if (v_i >= NEG_THRESH) level_c_o = LVL_NEG_IN;
      else                   level_c_o = LVL_NEG_OUT;
    end
  end

endmodule

// File: rtl/qam_coherent_demod.sv
// Coherent 16-QAM demodulator: mixes each accepted sample with cos/sin
// references, integrates over SYM_LEN samples and slices the dumped sums.
// Ports: clk, rst_n (async active-low)
//        bus (slave): en/sync/rx_sample/cos_ref/sin_ref in,
//                     i_acc/q_acc/sym_bits/sym_valid out (all registered)
module qam_coherent_demod
  import qam_demod_pkg::*;
#(
  parameter int unsigned                 SAMPLE_WIDTH = 16,
  parameter int unsigned                 REF_WIDTH    = 16,
  parameter int unsigned                 SYM_LEN      = 64,
  parameter int unsigned                 ACC_WIDTH    = 40,
  parameter logic signed [ACC_WIDTH-1:0] THRESH       = ACC_WIDTH'(1) << 28
) (
  input logic                 clk,
  input logic                 rst_n,
  qam_coherent_demod_if.slave bus
);

  localparam int unsigned    PROD_W   = SAMPLE_WIDTH + REF_WIDTH;
  localparam int unsigned    CNT_W    = clog2(SYM_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYM_LEN - 1);

  // Elaboration-time guard on parameter legality.
  if (SYM_LEN < 2 || SYM_LEN > 4096 || ACC_WIDTH < PROD_W + clog2(SYM_LEN)) begin : g_bad_params
    $error("qam_coherent_demod: illegal SYM_LEN/ACC_WIDTH combination");
  end

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      s1_vld_q;
  logic                      s1_first_q;
  logic                      s1_last_q;
  logic signed [PROD_W-1:0]  p_i_q;
  logic signed [PROD_W-1:0]  p_q_q;
  logic signed [ACC_WIDTH-1:0] acc_i_q;
  logic signed [ACC_WIDTH-1:0] acc_q_q;
  logic signed [ACC_WIDTH-1:0] i_acc_q;
  logic signed [ACC_WIDTH-1:0] q_acc_q;
  logic [3:0]                sym_bits_q;
  logic                      sym_valid_q;

  logic                      accept_c;
  logic [CNT_W-1:0]          idx_c;
  logic signed [PROD_W-1:0]  prod_i_c;
  logic signed [PROD_W-1:0]  prod_q_c;
  logic signed [ACC_WIDTH-1:0] sum_i_c;
  logic signed [ACC_WIDTH-1:0] sum_q_c;
  logic [1:0]                lvl_i_c;
  logic [1:0]                lvl_q_c;

  // Sample acceptance and its symbol index; sync always restarts at index 0.
  always_comb begin
    accept_c = bus.en && ((state_q == RUN) || bus.sync);
    idx_c    = bus.sync ? '0 : cnt_q;
    prod_i_c = PROD_W'(bus.rx_sample) * PROD_W'(bus.cos_ref);
    prod_q_c = PROD_W'(bus.rx_sample) * PROD_W'(bus.sin_ref);
  end

  // A first-tagged product restarts the integral, which drops any partial symbol.
  always_comb begin
    sum_i_c = s1_first_q ? ACC_WIDTH'(p_i_q) : acc_i_q + ACC_WIDTH'(p_i_q);
    sum_q_c = s1_first_q ? ACC_WIDTH'(p_q_q) : acc_q_q + ACC_WIDTH'(p_q_q);
  end

  qam_axis_slicer #(
    .ACC_WIDTH (ACC_WIDTH),
    .THRESH    (THRESH)
  ) u_slice_i (
    .v_i       (sum_i_c),
    .level_c_o (lvl_i_c)
  );

  qam_axis_slicer #(
    .ACC_WIDTH (ACC_WIDTH),
    .THRESH    (THRESH)
  ) u_slice_q (
    .v_i       (sum_q_c),
    .level_c_o (lvl_q_c)
  );

  // FSM, sample counter and stage-1 product/tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      p_i_q      <= '0;
      p_q_q      <= '0;
    end else begin
      s1_vld_q <= accept_c;
      if (accept_c) begin
        state_q    <= RUN;
        cnt_q      <= (idx_c == LAST_IDX) ? '0 : idx_c + CNT_W'(1);
        s1_first_q <= (idx_c == '0);
        s1_last_q  <= (idx_c == LAST_IDX);
        p_i_q      <= prod_i_c;
        p_q_q      <= prod_q_c;
      end
    end
  end

  // Stage 2: integrate, and on the last sample dump, slice and strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      i_acc_q     <= '0;
      q_acc_q     <= '0;
      sym_bits_q  <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      sym_valid_q <= 1'b0;
      if (s1_vld_q) begin
        if (s1_last_q) begin
          i_acc_q     <= sum_i_c;
          q_acc_q     <= sum_q_c;
          sym_bits_q  <= {lvl_i_c, lvl_q_c};
          sym_valid_q <= 1'b1;
          acc_i_q     <= '0;
          acc_q_q     <= '0;
        end else begin
          acc_i_q <= sum_i_c;
          acc_q_q <= sum_q_c;
        end
      end
    end
  end

  assign bus.i_acc     = i_acc_q;
  assign bus.q_acc     = q_acc_q;
  assign bus.sym_bits  = sym_bits_q;
  assign bus.sym_valid = sym_valid_q;

endmodule

// File: tb/tb_qam_coherent_demod.sv
// Self-checking bench for qam_coherent_demod (SYM_LEN=4, THRESH=200000).
module tb_qam_coherent_demod;

  localparam int unsigned SW = 16;
  localparam int unsigned RW = 16;
  localparam int unsigned AW = 40;
  localparam int          SYM_LEN_TB = 4;
  localparam longint      THRESH_TB  = 200000;

  logic clk;
  logic rst_n;

  qam_coherent_demod_if #(.SAMPLE_WIDTH(SW), .REF_WIDTH(RW), .ACC_WIDTH(AW)) bus ();

  qam_coherent_demod #(
    .SAMPLE_WIDTH (SW),
    .REF_WIDTH    (RW),
    .SYM_LEN      (SYM_LEN_TB),
    .ACC_WIDTH    (AW),
    .THRESH       (40'sd200000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    longint     i;
    longint     q;
    logic [3:0] bits;
    int         due;
  } exp_t;

  exp_t   exp_q[$];
  bit     running = 1'b0;
  int     midx    = 0;
  longint si      = 0;
  longint sq      = 0;
  longint last_i  = 0;
  longint last_q  = 0;
  logic [3:0] last_b = '0;

  function automatic logic [1:0] slice(input longint v);
    if (v < -THRESH_TB)     return 2'b00;
    else if (v < 0)         return 2'b01;
    else if (v < THRESH_TB) return 2'b11;
    else                    return 2'b10;
  endfunction

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of input and update the symbol-level model for it.
  task automatic step(input logic e, input logic sy, input logic signed [15:0] rx,
                      input logic signed [15:0] cr, input logic signed [15:0] sr);
    exp_t x;
    bus.en        = e;
    bus.sync      = sy;
    bus.rx_sample = rx;
    bus.cos_ref   = cr;
    bus.sin_ref   = sr;
    if (rst_n && e) begin
      if (sy) begin
        running = 1'b1;
        midx = 0; si = 0; sq = 0;
      end
      if (running) begin
        si += longint'(rx) * longint'(cr);
        sq += longint'(rx) * longint'(sr);
        midx++;
        if (midx == SYM_LEN_TB) begin
          x.i    = si;
          x.q    = sq;
          x.bits = {slice(si), slice(sq)};
          x.due  = cyc + 2;
          exp_q.push_back(x);
          midx = 0; si = 0; sq = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic logic signed [15:0] rnd16();
    return 16'($urandom);
  endfunction

  // Per-cycle comparison of every output against the model.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_i = 0; last_q = 0; last_b = '0;
        chk_eq("rst_valid", longint'(bus.sym_valid), 0);
        chk_eq("rst_i_acc", longint'(bus.i_acc), 0);
        chk_eq("rst_q_acc", longint'(bus.q_acc), 0);
        chk_eq("rst_bits",  longint'(bus.sym_bits), 0);
      end else begin
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk_eq("sym_valid", longint'(bus.sym_valid), longint'(ev));
        if (ev) begin
          last_i = exp_q[0].i;
          last_q = exp_q[0].q;
          last_b = exp_q[0].bits;
          void'(exp_q.pop_front());
        end
        chk_eq("i_acc", longint'(bus.i_acc), last_i);
        chk_eq("q_acc", longint'(bus.q_acc), last_q);
        chk_eq("sym_bits", longint'(bus.sym_bits), longint'(last_b));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.sync = 1'b0;
    bus.rx_sample = '0; bus.cos_ref = '0; bus.sin_ref = '0;

    // Reset held with random activity, then unsynced samples are ignored.
    for (int k = 0; k < 5; k++) step(1'($urandom), 1'($urandom), rnd16(), rnd16(), rnd16());
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, rnd16(), rnd16(), rnd16());
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, '0, '0);

    // Basic symbol.
    step(1'b1, 1'b1, 16'sd1000, 16'sd100, 16'sd0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'sd1000, 16'sd100, 16'sd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, '0, '0);
    chk_eq("basic_i_lit", longint'(bus.i_acc), 400000);
    chk_eq("basic_q_lit", longint'(bus.q_acc), 0);
    chk_eq("basic_bits_lit", longint'(bus.sym_bits), 11);

    // Negative / inner levels.
    step(1'b1, 1'b1, -16'sd500, 16'sd50, -16'sd100);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, -16'sd500, 16'sd50, -16'sd100);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, '0, '0);
    chk_eq("neg_i_lit", longint'(bus.i_acc), -100000);
    chk_eq("neg_q_lit", longint'(bus.q_acc), 200000);
    chk_eq("neg_bits_lit", longint'(bus.sym_bits), 6);

    // en gaps (sync pulses while en=0 must be ignored).
    for (int k = 0; k < 4; k++) begin
      step(1'b1, (k == 0), 16'sd1000, 16'sd100, 16'sd0);
      for (int g = 0; g < 3; g++) step(1'b0, 1'($urandom), rnd16(), rnd16(), rnd16());
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, '0, '0);
    chk_eq("gap_i_lit", longint'(bus.i_acc), 400000);
    chk_eq("gap_bits_lit", longint'(bus.sym_bits), 11);

    // Back-to-back symbols.
    for (int k = 0; k < 12; k++) step(1'b1, (k == 0), rnd16(), rnd16(), rnd16());
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, '0, '0);

    // Resync after a partial symbol.
    step(1'b1, 1'b1, 16'sd1000, 16'sd100, 16'sd0);
    step(1'b1, 1'b0, 16'sd1000, 16'sd100, 16'sd0);
    step(1'b1, 1'b1, -16'sd1000, 16'sd100, 16'sd0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, -16'sd1000, 16'sd100, 16'sd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, '0, '0);
    chk_eq("resync_i_lit", longint'(bus.i_acc), -400000);
    chk_eq("resync_bits_i_lit", longint'(bus.sym_bits[3:2]), 0);

    // Random traffic with occasional resync.
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 5), rnd16(), rnd16(), rnd16());
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, '0, '0);

    // Asynchronous reset in the middle of a symbol.
    step(1'b1, 1'b1, 16'sd1000, 16'sd100, 16'sd50);
    step(1'b1, 1'b0, 16'sd1000, 16'sd100, 16'sd50);
    #2;
    rst_n = 1'b0;
    running = 1'b0; midx = 0; si = 0; sq = 0;
    exp_q.delete();
    #1;
    chk_eq("async_rst_i_lit", longint'(bus.i_acc), 0);
    chk_eq("async_rst_q_lit", longint'(bus.q_acc), 0);
    chk_eq("async_rst_bits_lit", longint'(bus.sym_bits), 0);
    chk_eq("async_rst_valid_lit", longint'(bus.sym_valid), 0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) step(1'b1, 1'b0, rnd16(), rnd16(), rnd16());
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, rnd16(), rnd16(), rnd16());
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, '0, '0);
    chk_eq("post_rst_i_lit", longint'(bus.i_acc), 0);
    chk_eq("pending_strobes", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
